matmul_apb_regs: RTL

APB3 slave front-end of the matrix-multiplier IP. It decodes the five-register map and drives pready/pslverr/prdata. It issues the start pulse to the compute core, stages scratchpad writes and reads through an auto-incrementing address pointer, and generates busy_o. It sits directly upstream of the matmul core and scratchpad, and is the source of the bus-side behaviour that the IP's protocol checker monitors.

---
 rtl/matmul_apb_regs.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/matmul_apb_regs.sv
// +------------------------------------------------------------------------+
// | matmul_apb_regs : APB3 register front-end of the matrix-multiplier IP  |
// | Revision 1.0                                                           |
// +------------------------------------------------------------------------+
`default_nettype none

module matmul_apb_regs #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SP_NTARGETS = 3,
  parameter int SP_ADDR_W   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [ADDR_W-1:0]    paddr_i,
  input  logic [DATA_W-1:0]    pwdata_i,
  output logic [DATA_W-1:0]    prdata_o,
  output logic                 pready_o,
  output logic                 pslverr_o,
  output logic                 busy_o,
  output logic                 start_o,
  output logic [1:0]           wr_tgt_o,
  output logic [1:0]           rd_tgt_o,
  input  logic                 busy_i,
  input  logic                 done_i,
  output logic                 sp_we_o,
  output logic                 sp_re_o,
  output logic [1:0]           sp_sel_o,
  output logic [SP_ADDR_W-1:0] sp_addr_o,
  output logic [DATA_W-1:0]    sp_wdata_o,
  input  logic [DATA_W-1:0]    sp_rdata_i
);

  localparam logic [4:0] C_A_CTRL = 5'h00;
  localparam logic [4:0] C_A_ADDR = 5'h04;
  localparam logic [4:0] C_A_DATA = 5'h08;
  localparam logic [4:0] C_A_STAT = 5'h0C;
  localparam logic [4:0] C_A_RDAT = 5'h10;
  localparam logic [2:0] C_NTGT   = 3'(SP_NTARGETS);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RD_WAIT = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [3:0]           ctrl_q, ctrl_d;      // {RD_TGT, WR_TGT}
  logic [SP_ADDR_W-1:0] addr_q, addr_d;
  logic                 done_q, done_d;
  logic                 launch_q, launch_d;
  logic                 start_q, start_d;
  logic                 we_q, we_d;
  logic [1:0]           wsel_q, wsel_d;
  logic [SP_ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;

  logic       w_access;
  logic [4:0] w_off;
  logic       w_tgt_bad;
  logic       w_wr_err;
  logic       w_sp_re;
  logic       unused_paddr;

  assign unused_paddr = ^paddr_i[ADDR_W-1:5];
  assign w_access     = psel_i & penable_i;
  assign w_off        = paddr_i[4:0];
  assign busy_o       = busy_i | launch_q;
  assign w_tgt_bad    = ({1'b0, pwdata_i[3:2]} >= C_NTGT) || ({1'b0, pwdata_i[5:4]} >= C_NTGT);
  assign w_wr_err     = !(w_off inside {C_A_CTRL, C_A_ADDR, C_A_DATA}) || busy_o ||
                        ((w_off == C_A_CTRL) && w_tgt_bad);

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    addr_d    = addr_q;
    done_d    = done_q;
    launch_d  = launch_q;
    start_d   = 1'b0;
    we_d      = 1'b0;
    wsel_d    = wsel_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    pready_o  = 1'b0;
    pslverr_o = 1'b0;
    prdata_o  = '0;
    w_sp_re   = 1'b0;

    // launch_q only bridges the gap until the core reports busy
    if (busy_i) launch_d = 1'b0;

    if (done_i) begin
      done_d = 1'b1;
    end else if (w_access && !pwrite_i && (state_q == S_IDLE) && (w_off == C_A_STAT)) begin
      done_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (w_access && pwrite_i) begin
          pready_o  = 1'b1;
          pslverr_o = w_wr_err;
          if (!w_wr_err) begin
            case (w_off)
              C_A_CTRL: begin
                ctrl_d = pwdata_i[5:2];
                if (pwdata_i[0]) begin
                  launch_d = 1'b1;
                  start_d  = 1'b1;
                end
              end
              C_A_ADDR: addr_d = pwdata_i[SP_ADDR_W-1:0];
              default: begin
                we_d    = 1'b1;
                wsel_d  = ctrl_q[1:0];
                waddr_d = addr_q;
                wdata_d = pwdata_i;
                addr_d  = addr_q + SP_ADDR_W'(1);
              end
            endcase
          end
        end else if (w_access) begin
          pready_o = 1'b1;
          case (w_off)
            C_A_CTRL: prdata_o = DATA_W'({ctrl_q, 2'b00});
            C_A_ADDR: prdata_o = DATA_W'(addr_q);
            C_A_DATA: prdata_o = '0;
            C_A_STAT: prdata_o = DATA_W'({done_q, busy_o});
            C_A_RDAT: begin
              if (!busy_o) begin
                pready_o = 1'b0;
                w_sp_re  = 1'b1;
                state_d  = S_RD_WAIT;
              end
            end
            default:  pslverr_o = 1'b1;
          endcase
        end
      end
      default: begin
        // An abandoned read (psel dropped) leaves the pointer untouched
        state_d = S_IDLE;
        if (w_access) begin
          pready_o = 1'b1;
          prdata_o = sp_rdata_i;
          addr_d   = addr_q + SP_ADDR_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      ctrl_q   <= '0;
      addr_q   <= '0;
      done_q   <= 1'b0;
      launch_q <= 1'b0;
      start_q  <= 1'b0;
      we_q     <= 1'b0;
      wsel_q   <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
      launch_q <= launch_d;
      start_q  <= start_d;
      we_q     <= we_d;
      wsel_q   <= wsel_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign start_o    = start_q;
  assign wr_tgt_o   = ctrl_q[1:0];
  assign rd_tgt_o   = ctrl_q[3:2];
  assign sp_we_o    = we_q;
  assign sp_re_o    = w_sp_re;
  assign sp_sel_o   = we_q ? wsel_q  : (w_sp_re ? ctrl_q[3:2] : 2'b00);
  assign sp_addr_o  = we_q ? waddr_q : (w_sp_re ? addr_q : '0);
  assign sp_wdata_o = we_q ? wdata_q : '0;

endmodule

`default_nettype wire
